// File: rtl/mips_pkg.sv
// Shared datapath constants and the fetch-stage state type.
package mips_pkg;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // Instruction addresses are word aligned; the low two bits of a target are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bus between the fetch stage, instruction memory, the hazard/branch logic and decode.
interface fetch_stage_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      imem_addr;
  logic [31:0]      imem_rdata;
  logic             stall;
  logic             flush;
  logic             redirect_en;
  logic [31:0]      redirect_pc;
  logic [31:0]      pc_out;
  logic [31:0]      if_id_instr;
  logic [31:0]      if_id_pc4;
  logic             if_id_valid;
  logic             halted;
  logic [CNT_W-1:0] fetch_count;

  modport master (
    output imem_addr, pc_out, if_id_instr, if_id_pc4, if_id_valid, halted, fetch_count,
    input  imem_rdata, stall, flush, redirect_en, redirect_pc
  );

  modport slave (
    input  imem_addr, pc_out, if_id_instr, if_id_pc4, if_id_valid, halted, fetch_count,
    output imem_rdata, stall, flush, redirect_en, redirect_pc
  );
endinterface

// File: rtl/ALU_add_only.sv
// Plain 32-bit modulo adder shared by the PC and branch-target paths.
module ALU_add_only (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);
  assign sum = a + b;
endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: {valid, instr, pc4}; bubble beats load, otherwise it holds.
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] instr_d,
  input  logic [31:0] pc4_d,
  output logic [31:0] instr_q,
  output logic [31:0] pc4_q,
  output logic        valid_q
);
  localparam logic [64:0] BUBBLE_VAL = {1'b0, NOP_WORD, 32'h0000_0000};

  logic [64:0] data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      data_q <= BUBBLE_VAL;
    else if (bubble)
      data_q <= BUBBLE_VAL;
    else if (load)
      data_q <= {1'b1, instr_d, pc4_d};
  end

  assign valid_q = data_q[64];
  assign instr_q = data_q[63:32];
  assign pc4_q   = data_q[31:0];
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, BOOT/RUN/HALT control and the IF/ID register feeding decode.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter int          CNT_W     = 16
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);
  fetch_state_t     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pc_plus4;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ifid_load;
  logic             ifid_bubble;

  ALU_add_only u_pc_adder (
    .a   (pc_q),
    .b   (PC_STEP),
    .sum (pc_plus4)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  // Redirect outranks everything; a stall only freezes RUN, never BOOT or HALT.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    count_d     = count_q;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    unique case (state_q)
      BOOT: begin
        ifid_bubble = 1'b1;
        state_d     = RUN;
        if (bus.redirect_en)
          pc_d = align_pc(bus.redirect_pc);
      end
      RUN: begin
        if (bus.redirect_en) begin
          ifid_bubble = 1'b1;
          pc_d        = align_pc(bus.redirect_pc);
        end else if (bus.flush) begin
          ifid_bubble = 1'b1;
          if (!bus.stall)
            pc_d = pc_plus4;
        end else if (bus.stall) begin
          pc_d = pc_q;
        end else if (bus.imem_rdata == HALT_WORD) begin
          ifid_bubble = 1'b1;
          state_d     = HALT;
        end else begin
          ifid_load = 1'b1;
          pc_d      = pc_plus4;
          count_d   = count_q + CNT_W'(1);
        end
      end
      HALT: begin
        ifid_bubble = 1'b1;
        if (bus.redirect_en) begin
          pc_d    = align_pc(bus.redirect_pc);
          state_d = RUN;
        end
      end
      default: begin
        ifid_bubble = 1'b1;
        state_d     = BOOT;
      end
    endcase
  end

  if_id_reg u_if_id (
    .clk     (clk),
    .reset   (reset),
    .load    (ifid_load),
    .bubble  (ifid_bubble),
    .instr_d (bus.imem_rdata),
    .pc4_d   (pc_plus4),
    .instr_q (bus.if_id_instr),
    .pc4_q   (bus.if_id_pc4),
    .valid_q (bus.if_id_valid)
  );

  assign bus.pc_out      = pc_q;
  assign bus.imem_addr   = pc_q;
  assign bus.halted      = (state_q == HALT);
  assign bus.fetch_count = count_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, boot, stall, flush, redirect, halt and wrap cases.
module tb_fetch_stage;
  logic clk;
  logic reset;
  logic halt_mode;
  int   total;
  int   bad;

  fetch_stage_if #(.CNT_W(16)) bus ();

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .HALT_WORD (32'hFFFF_FFFF),
    .CNT_W     (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: word 0 is addi $t0,$0,5; every other word tags its own address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return {16'h2400, a[15:0]};
  endfunction

  assign bus.imem_rdata = halt_mode ? 32'hFFFF_FFFF : mem_word(bus.imem_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    total++; if (bus.pc_out !== 32'h0) begin bad++; $display("[TB] FAIL rst_pc got %h want %h", bus.pc_out, 32'h0); end
    total++; if (bus.if_id_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid got %b want 0", bus.if_id_valid); end
    total++; if (bus.if_id_instr !== 32'h0) begin bad++; $display("[TB] FAIL rst_instr got %h want 0", bus.if_id_instr); end
    total++; if (bus.halted !== 1'b0) begin bad++; $display("[TB] FAIL rst_halted got %b want 0", bus.halted); end
    total++; if (bus.fetch_count !== 16'd0) begin bad++; $display("[TB] FAIL rst_count got %0d want 0", bus.fetch_count); end
    step();
    step();
    reset = 1'b0;
    step();
    total++; if (bus.if_id_valid !== 1'b0) begin bad++; $display("[TB] FAIL boot_valid got %b want 0", bus.if_id_valid); end
    total++; if (bus.pc_out !== 32'h0) begin bad++; $display("[TB] FAIL boot_pc got %h want 0", bus.pc_out); end
    step();
    total++; if (bus.if_id_instr !== 32'h2008_0005) begin bad++; $display("[TB] FAIL first_instr got %h want 20080005", bus.if_id_instr); end
    total++; if (bus.if_id_pc4 !== 32'h4) begin bad++; $display("[TB] FAIL first_pc4 got %h want 4", bus.if_id_pc4); end
    total++; if (bus.if_id_valid !== 1'b1) begin bad++; $display("[TB] FAIL first_valid got %b want 1", bus.if_id_valid); end
    total++; if (bus.pc_out !== 32'h4) begin bad++; $display("[TB] FAIL first_pc got %h want 4", bus.pc_out); end
    total++; if (bus.fetch_count !== 16'd1) begin bad++; $display("[TB] FAIL first_count got %0d want 1", bus.fetch_count); end
  endtask

  task automatic test_stall();
    step();
    total++; if (bus.pc_out !== 32'h8) begin bad++; $display("[TB] FAIL pre_stall_pc got %h want 8", bus.pc_out); end
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (bus.pc_out !== 32'h8) begin bad++; $display("[TB] FAIL stall_pc[%0d] got %h want 8", i, bus.pc_out); end
      total++; if (bus.if_id_instr !== 32'h2400_0004 || bus.if_id_pc4 !== 32'h8) begin bad++; $display("[TB] FAIL stall_ifid[%0d] got %h/%h want 24000004/00000008", i, bus.if_id_instr, bus.if_id_pc4); end
      total++; if (bus.fetch_count !== 16'd2) begin bad++; $display("[TB] FAIL stall_count[%0d] got %0d want 2", i, bus.fetch_count); end
    end
    bus.stall = 1'b0;
    step();
    total++; if (bus.pc_out !== 32'hC) begin bad++; $display("[TB] FAIL unstall_pc got %h want c", bus.pc_out); end
    total++; if (bus.if_id_instr !== 32'h2400_0008 || bus.fetch_count !== 16'd3) begin bad++; $display("[TB] FAIL unstall_fetch got %h/%0d want 24000008/3", bus.if_id_instr, bus.fetch_count); end
  endtask

  task automatic test_redirect_stall();
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 32'h0000_0043;
    bus.stall       = 1'b1;
    step();
    bus.redirect_en = 1'b0;
    bus.stall       = 1'b0;
    total++; if (bus.pc_out !== 32'h40) begin bad++; $display("[TB] FAIL redir_pc got %h want 40", bus.pc_out); end
    total++; if (bus.if_id_valid !== 1'b0 || bus.if_id_instr !== 32'h0) begin bad++; $display("[TB] FAIL redir_bubble got %b/%h want 0/00000000", bus.if_id_valid, bus.if_id_instr); end
    total++; if (bus.fetch_count !== 16'd3) begin bad++; $display("[TB] FAIL redir_count got %0d want 3", bus.fetch_count); end
  endtask

  task automatic test_flush();
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 32'h0000_000C;
    step();
    bus.redirect_en = 1'b0;
    step();
    total++; if (bus.pc_out !== 32'h10 || bus.if_id_valid !== 1'b1 || bus.fetch_count !== 16'd4) begin bad++; $display("[TB] FAIL pre_flush got pc=%h v=%b n=%0d want 10/1/4", bus.pc_out, bus.if_id_valid, bus.fetch_count); end
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    total++; if (bus.pc_out !== 32'h14) begin bad++; $display("[TB] FAIL flush_pc got %h want 14", bus.pc_out); end
    total++; if (bus.if_id_valid !== 1'b0 || bus.if_id_pc4 !== 32'h0) begin bad++; $display("[TB] FAIL flush_bubble got %b/%h want 0/00000000", bus.if_id_valid, bus.if_id_pc4); end
    bus.flush = 1'b1;
    bus.stall = 1'b1;
    step();
    total++; if (bus.pc_out !== 32'h14) begin bad++; $display("[TB] FAIL flush_stall_pc got %h want 14", bus.pc_out); end
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    step();
    total++; if (bus.if_id_instr !== 32'h2400_0014 || bus.pc_out !== 32'h18 || bus.fetch_count !== 16'd5) begin bad++; $display("[TB] FAIL post_flush got %h/%h/%0d want 24000014/18/5", bus.if_id_instr, bus.pc_out, bus.fetch_count); end
    bus.flush = 1'b1;
    bus.stall = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    total++; if (bus.if_id_valid !== 1'b0 || bus.if_id_instr !== 32'h0 || bus.pc_out !== 32'h18) begin bad++; $display("[TB] FAIL flush_stall_valid got %b/%h/%h want 0/00000000/18", bus.if_id_valid, bus.if_id_instr, bus.pc_out); end
  endtask

  task automatic test_halt();
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 32'h0000_001C;
    step();
    bus.redirect_en = 1'b0;
    step();
    total++; if (bus.pc_out !== 32'h20 || bus.fetch_count !== 16'd6) begin bad++; $display("[TB] FAIL pre_halt got %h/%0d want 20/6", bus.pc_out, bus.fetch_count); end
    halt_mode = 1'b1;
    step();
    total++; if (bus.halted !== 1'b1) begin bad++; $display("[TB] FAIL halt_enter got %b want 1", bus.halted); end
    total++; if (bus.pc_out !== 32'h20 || bus.if_id_valid !== 1'b0) begin bad++; $display("[TB] FAIL halt_state got %h/%b want 20/0", bus.pc_out, bus.if_id_valid); end
    for (int i = 0; i < 5; i++) begin
      bus.stall = i[0];
      bus.flush = i[1];
      step();
      total++; if (bus.halted !== 1'b1 || bus.pc_out !== 32'h20 || bus.imem_addr !== 32'h20 || bus.if_id_valid !== 1'b0) begin bad++; $display("[TB] FAIL halt_hold[%0d] got h=%b pc=%h a=%h v=%b want 1/20/20/0", i, bus.halted, bus.pc_out, bus.imem_addr, bus.if_id_valid); end
    end
    bus.stall       = 1'b0;
    bus.flush       = 1'b0;
    halt_mode       = 1'b0;
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 32'h0000_0100;
    step();
    bus.redirect_en = 1'b0;
    total++; if (bus.halted !== 1'b0 || bus.pc_out !== 32'h100 || bus.if_id_valid !== 1'b0) begin bad++; $display("[TB] FAIL halt_exit got %b/%h/%b want 0/100/0", bus.halted, bus.pc_out, bus.if_id_valid); end
    step();
    total++; if (bus.if_id_instr !== 32'h2400_0100 || bus.if_id_pc4 !== 32'h104 || bus.fetch_count !== 16'd7) begin bad++; $display("[TB] FAIL halt_resume got %h/%h/%0d want 24000100/104/7", bus.if_id_instr, bus.if_id_pc4, bus.fetch_count); end
  endtask

  task automatic test_wrap();
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFE;
    step();
    bus.redirect_en = 1'b0;
    total++; if (bus.pc_out !== 32'hFFFF_FFFC) begin bad++; $display("[TB] FAIL wrap_align got %h want fffffffc", bus.pc_out); end
    step();
    total++; if (bus.pc_out !== 32'h0 || bus.if_id_pc4 !== 32'h0) begin bad++; $display("[TB] FAIL wrap_pc got %h/%h want 0/0", bus.pc_out, bus.if_id_pc4); end
    total++; if (bus.if_id_instr !== 32'h2400_FFFC || bus.if_id_valid !== 1'b1 || bus.fetch_count !== 16'd8) begin bad++; $display("[TB] FAIL wrap_fetch got %h/%b/%0d want 2400fffc/1/8", bus.if_id_instr, bus.if_id_valid, bus.fetch_count); end
  endtask

  task automatic test_halt_stall_reset();
    halt_mode = 1'b1;
    bus.stall = 1'b1;
    step();
    total++; if (bus.halted !== 1'b0 || bus.pc_out !== 32'h0 || bus.if_id_instr !== 32'h2400_FFFC) begin bad++; $display("[TB] FAIL halt_stalled got %b/%h/%h want 0/0/2400fffc", bus.halted, bus.pc_out, bus.if_id_instr); end
    bus.stall = 1'b0;
    step();
    total++; if (bus.halted !== 1'b1) begin bad++; $display("[TB] FAIL halt_after_stall got %b want 1", bus.halted); end
    reset = 1'b1;
    #2;
    total++; if (bus.halted !== 1'b0 || bus.pc_out !== 32'h0 || bus.fetch_count !== 16'd0 || bus.if_id_valid !== 1'b0) begin bad++; $display("[TB] FAIL async_reset got %b/%h/%0d/%b want 0/0/0/0", bus.halted, bus.pc_out, bus.fetch_count, bus.if_id_valid); end
    halt_mode = 1'b0;
    step();
    reset           = 1'b0;
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 32'h0000_0081;
    step();
    bus.redirect_en = 1'b0;
    total++; if (bus.pc_out !== 32'h80 || bus.if_id_valid !== 1'b0) begin bad++; $display("[TB] FAIL boot_redir got %h/%b want 80/0", bus.pc_out, bus.if_id_valid); end
    step();
    total++; if (bus.if_id_instr !== 32'h2400_0080 || bus.if_id_pc4 !== 32'h84 || bus.fetch_count !== 16'd1) begin bad++; $display("[TB] FAIL boot_redir_fetch got %h/%h/%0d want 24000080/84/1", bus.if_id_instr, bus.if_id_pc4, bus.fetch_count); end
  endtask

  initial begin
    total           = 0;
    bad             = 0;
    halt_mode       = 1'b0;
    bus.stall       = 1'b0;
    bus.flush       = 1'b0;
    bus.redirect_en = 1'b0;
    bus.redirect_pc = 32'h0;
    test_reset();
    test_stall();
    test_redirect_stall();
    test_flush();
    test_halt();
    test_wrap();
    test_halt_stall_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
